// File: rtl/riscv_fetch_buf.sv
// Instruction fetch unit: sequential prefetch over a req/gnt/rvalid port into a
// circular queue of {pc, instruction}, with redirect flush and stale-response discard.
module riscv_fetch_buf #(
  parameter int              DW        = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [DW-1:0]   RESET_PC  = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [DW-1:0]              redirect_pc_i,
  output logic                       imem_req_o,
  output logic [DW-1:0]              imem_addr_o,
  input  logic                       imem_gnt_i,
  input  logic                       imem_rvalid_i,
  input  logic [DW-1:0]              imem_rdata_i,
  output logic                       inst_valid_o,
  output logic [DW-1:0]              inst_o,
  output logic [DW-1:0]              inst_pc_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;
  localparam int SW = CW + 1;

  logic [DW-1:0] mem_pc   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outst, discard, outst_nx;
  logic [DW-1:0] fetch_pc, resp_pc;
  logic [DW-1:0] redirect_pc_al;

  logic space_ok, req, fire, rsp, push, pop, valid;

  // Reserving queue space for every in-flight request means a push can never overflow.
  always_comb begin
    space_ok       = (SW'(count) + SW'(outst)) < SW'(DEPTH);
    req            = !rst_i && !redirect_i && (outst < OW'(MAX_OUTST)) && space_ok;
    fire           = req && imem_gnt_i;
    rsp            = imem_rvalid_i && (outst != '0);
    push           = rsp && !redirect_i && (discard == '0);
    valid          = (count != '0) && !redirect_i;
    pop            = valid && inst_ready_i;
    outst_nx       = outst + OW'(fire) - OW'(rsp);
    redirect_pc_al = {redirect_pc_i[DW-1:2], 2'b00};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      count    <= '0;
      outst    <= '0;
      discard  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_i) begin
      // every word still in flight belongs to the abandoned stream
      fetch_pc <= redirect_pc_al;
      resp_pc  <= redirect_pc_al;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      outst    <= outst_nx;
      discard  <= outst_nx;
    end else begin
      outst <= outst_nx;
      if (fire) fetch_pc <= fetch_pc + DW'(4);
      if (rsp && (discard != '0)) discard <= discard - OW'(1);
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        resp_pc <= resp_pc + DW'(4);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_pc[wr_ptr]   <= resp_pc;
      mem_data[wr_ptr] <= imem_rdata_i;
    end
  end

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc;
  assign inst_valid_o = valid;
  assign inst_o       = valid ? mem_data[rd_ptr] : '0;
  assign inst_pc_o    = valid ? mem_pc[rd_ptr] : '0;
  assign count_o      = count;

endmodule

// File: tb/tb_riscv_fetch_buf.sv
// Directed bench for riscv_fetch_buf: in-order memory model with programmable latency
// and a scoreboard of expected {pc, instruction} pairs checked at every pop.
module tb_riscv_fetch_buf;
  logic        clk = 1'b0;
  logic        rst_i, redirect_i, imem_gnt_i, inst_ready_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o, imem_rvalid_i, inst_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, inst_o, inst_pc_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  int unsigned lat = 1;
  int unsigned cyc = 0;

  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  pend_t pend[$];
  exp_t  sb[$];

  logic        model_rv = 1'b0;
  logic [31:0] model_rd = '0;
  logic        stray_rv = 1'b0;

  assign imem_rvalid_i = model_rv | stray_rv;
  assign imem_rdata_i  = stray_rv ? 32'hBAD0_BAD0 : model_rd;

  always #5 clk = ~clk;

  riscv_fetch_buf dut (
    .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i), .count_o(count_o)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // memory: accepts on req&gnt, answers in order once the latency has elapsed
  always @(posedge clk) begin
    if (rst_i) pend.delete();
    else begin
      if (model_rv) pend.delete(0);
      if (imem_req_o && imem_gnt_i) pend.push_back('{imem_addr_o, cyc + lat});
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      model_rv = 1'b1;
      model_rd = word_of(pend[0].addr);
    end else begin
      model_rv = 1'b0;
      model_rd = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (inst_valid_o && inst_ready_i) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL pop_unexpected: observed pc %h expected no pop", inst_pc_o);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_pc", inst_pc_o, e.pc);
        chk("pop_inst", inst_o, e.ins);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_from(input logic [31:0] pc);
    sb.delete();
    for (int i = 0; i < 100; i++)
      sb.push_back('{pc + 32'(4 * i), word_of(pc + 32'(4 * i))});
  endtask

  task automatic wait_drain(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && sb.size() > target; i++) tick();
    chk(tag, 32'(sb.size() <= target), 32'd1);
  endtask

  initial begin
    #200000;
    $error("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    repeat (3) tick();
    #2;
    chk("rst_req",   32'(imem_req_o), 32'd0);
    chk("rst_addr",  imem_addr_o, 32'h0);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst",  inst_o, 32'h0);
    chk("rst_pc",    inst_pc_o, 32'h0);
    chk("rst_count", 32'(count_o), 32'd0);

    // sequential fetch, latency 1, consumer always ready
    tick(); rst_i = 1'b0; expect_from(32'h0); #2;
    chk("t1_req", 32'(imem_req_o), 32'd1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    tick(); #2;
    chk("t1_addr1", imem_addr_o, 32'h4);
    chk("t1_valid_early", 32'(inst_valid_o), 32'd0);
    tick(); #2;
    chk("t1_addr2", imem_addr_o, 32'h8);
    chk("t1_first_valid", 32'(inst_valid_o), 32'd1);
    chk("t1_first_pc", inst_pc_o, 32'h0);
    wait_drain(94, 20, "t1_stream");

    // consumer stalls: queue fills to DEPTH, fetching stops, head holds
    tick(); inst_ready_i = 1'b0;
    repeat (8) tick();
    #2;
    chk("t2_count_full", 32'(count_o), 32'd4);
    chk("t2_req_stop", 32'(imem_req_o), 32'd0);
    chk("t2_head_pc", inst_pc_o, sb[0].pc);
    chk("t2_head_inst", inst_o, sb[0].ins);
    tick(); #2;
    chk("t2_hold_pc", inst_pc_o, sb[0].pc);
    chk("t2_hold_count", 32'(count_o), 32'd4);
    chk("t2_hold_req", 32'(imem_req_o), 32'd0);
    tick(); inst_ready_i = 1'b1; #2;
    chk("t2_cnt_a", 32'(count_o), 32'd4);
    tick(); #2;
    chk("t2_cnt_b", 32'(count_o), 32'd3);
    tick(); #2;
    chk("t2_cnt_c", 32'(count_o), 32'd2);
    wait_drain(80, 20, "t2_stream");

    // redirect with two requests in flight, latency 3
    lat = 3;
    repeat (8) tick();
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (pend.size() == 2 && !model_rv) break;
    end
    chk("t3_setup", 32'(pend.size() == 2), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h100; expect_from(32'h100); #1;
    chk("t3_req_masked", 32'(imem_req_o), 32'd0);
    chk("t3_valid_masked", 32'(inst_valid_o), 32'd0);
    tick(); redirect_i = 1'b0; #2;
    chk("t3_addr", imem_addr_o, 32'h100);
    wait_drain(94, 60, "t3_stream");

    // unaligned redirect target
    lat = 1;
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h203; expect_from(32'h200);
    tick(); redirect_i = 1'b0; #2;
    chk("t4_addr", imem_addr_o, 32'h200);
    wait_drain(96, 30, "t4_stream");

    // redirect in a cycle carrying rvalid and gnt, another request still in flight
    lat = 2;
    repeat (6) tick();
    for (int i = 0; i < 20; i++) begin
      tick(); #1;
      if (model_rv && pend.size() == 2) break;
    end
    chk("t5_setup", 32'(model_rv && pend.size() == 2), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h400; expect_from(32'h400); #1;
    chk("t5_req_masked", 32'(imem_req_o), 32'd0);
    chk("t5_valid_masked", 32'(inst_valid_o), 32'd0);
    tick(); redirect_i = 1'b0; #2;
    chk("t5_count", 32'(count_o), 32'd0);
    chk("t5_addr", imem_addr_o, 32'h400);
    chk("t5_valid_after", 32'(inst_valid_o), 32'd0);
    wait_drain(95, 40, "t5_stream");

    // reset mid-operation with queued words and requests in flight
    lat = 3;
    tick(); inst_ready_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(); #2;
      if (pend.size() == 2 && count_o != 0) break;
    end
    chk("t6_setup", 32'(pend.size() == 2 && count_o != 0), 32'd1);
    rst_i = 1'b1; #1;
    chk("t6_req_in_rst", 32'(imem_req_o), 32'd0);
    lat = 1;
    tick(); rst_i = 1'b0; stray_rv = 1'b1; inst_ready_i = 1'b1; expect_from(32'h0); #2;
    chk("t6_count", 32'(count_o), 32'd0);
    chk("t6_valid", 32'(inst_valid_o), 32'd0);
    chk("t6_inst", inst_o, 32'h0);
    chk("t6_pc", inst_pc_o, 32'h0);
    chk("t6_addr", imem_addr_o, 32'h0);
    chk("t6_req", 32'(imem_req_o), 32'd1);
    tick(); stray_rv = 1'b0; #2;
    chk("t6_addr1", imem_addr_o, 32'h4);
    chk("t6_stray_dropped", 32'(inst_valid_o), 32'd0);
    tick(); #2;
    chk("t6_first_valid", 32'(inst_valid_o), 32'd1);
    chk("t6_first_inst", inst_o, word_of(32'h0));
    wait_drain(94, 20, "t6_stream");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
